// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core requesters, the arbiter and the unified memory.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_wstrb;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              gnt_d;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_addr, d_wstrb, d_wdata,
        input  mem_rdata,
        output if_ready, if_rdata,
        output d_ready, d_rdata,
        output mem_en, mem_addr, mem_wstrb, mem_wdata,
        output busy, gnt_d
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_addr, d_wstrb, d_wdata,
        output mem_rdata,
        input  if_ready, if_rdata,
        input  d_ready, d_rdata,
        input  mem_en, mem_addr, mem_wstrb, mem_wdata,
        input  busy, gnt_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Data has priority; a streak counter bounds how long a waiting fetch can starve.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [SW-1:0]     streak;
    logic [SW-1:0]     streak_nx;
    logic              abandon;
    logic              abandon_nx;
    logic              grant;
    logic              capture;
    logic              if_eff;
    logic              pick_d;

    logic              gnt_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [3:0]        mwstrb_q;
    logic [DATA_W-1:0] mwdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // A fetch presented in the same cycle as a flush targets a stale PC.
    assign if_eff = bus.if_req && !bus.if_flush;
    assign pick_d = bus.d_req &&
                    !(if_eff && streak == SW'(MAX_D_STREAK));

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        streak_nx  = streak;
        abandon_nx = abandon;
        grant      = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.d_req || if_eff) begin
                    grant    = 1'b1;
                    state_nx = ISSUE;
                    if (pick_d && if_eff) begin
                        if (streak != SW'(MAX_D_STREAK))
                            streak_nx = streak + SW'(1);
                    end else begin
                        streak_nx = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_nx   = CW'(MEM_LAT);
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            RESP: begin
                abandon_nx = 1'b0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if ((state == ISSUE || state == WAIT) && !gnt_q && bus.if_flush)
            abandon_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            streak  <= '0;
            abandon <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            streak  <= streak_nx;
            abandon <= abandon_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q      <= 1'b0;
            maddr_q    <= '0;
            mwstrb_q   <= 4'h0;
            mwdata_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant) begin
                gnt_q    <= pick_d;
                maddr_q  <= pick_d ? bus.d_addr : bus.if_addr;
                mwstrb_q <= pick_d ? bus.d_wstrb : 4'h0;
                mwdata_q <= pick_d ? bus.d_wdata : '0;
            end
            if (capture) begin
                if (gnt_q)
                    d_rdata_q <= (mwstrb_q != 4'h0) ? '0 : bus.mem_rdata;
                else if (!abandon && !bus.if_flush)
                    if_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = (state == ISSUE);
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wstrb = mwstrb_q;
    assign bus.mem_wdata = mwdata_q;
    assign bus.if_ready  = (state == RESP) && !gnt_q &&
                           !abandon && !bus.if_flush;
    assign bus.d_ready   = (state == RESP) && gnt_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.gnt_d     = gnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// that predicts grants, ready timing and returned data from the arbitration rules.
module tb_mem_port_arbiter;
    localparam int L    = 1;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MEM_LAT(L),
        .MAX_D_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h00500093;
            3:       return 32'h06300193;
            4:       return 32'h00208113;
            64:      return 32'hDEADBEEF;
            default: return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memory environment answering the DUT's own port.
    logic [31:0] env_mem [256];
    bit          env_wr  [256];
    logic [31:0] rd_pipe [L];

    function automatic logic [31:0] env_rd(input int i);
        return env_wr[i] ? env_mem[i] : init_word(i);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            rd_pipe[0] <= env_rd(int'(bus.mem_addr[9:2]));
            if (bus.mem_wstrb != 4'h0) begin
                env_mem[bus.mem_addr[9:2]] <= merge(env_rd(int'(bus.mem_addr[9:2])),
                                                    bus.mem_wdata, bus.mem_wstrb);
                env_wr[bus.mem_addr[9:2]]  <= 1'b1;
            end
        end
        for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.mem_rdata = rd_pipe[L-1];

    // Reference model state.
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    int          cyc;
    int          g_cyc;
    bit          inflight;
    bit          own_d;
    bit          aband;
    int          streak;
    logic [31:0] pend;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mwstrb;
    logic [31:0] exp_mwdata;
    logic        exp_gnt_d;
    bit          if_done;
    bit          d_done;
    bit          if_pend;
    bit          d_pend;
    int          checks;
    int          errors;

    function automatic logic [31:0] ref_rd(input int i);
        return ref_wr[i] ? ref_mem[i] : init_word(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        inflight     = 1'b0;
        aband        = 1'b0;
        streak       = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        exp_maddr    = '0;
        exp_mwstrb   = 4'h0;
        exp_mwdata   = '0;
        exp_gnt_d    = 1'b0;
        if_done      = 1'b0;
        d_done       = 1'b0;
    endtask

    task automatic eval();
        logic idle, rdy, e_if, e_d, e_en, eff_if, pick_d;
        logic [31:0] mv;
        int i;
        #1;
        idle = !inflight;
        e_en = inflight && cyc == g_cyc + 1;
        if (inflight && !own_d && bus.if_flush &&
            cyc >= g_cyc + 1 && cyc <= g_cyc + L + 1)
            aband = 1'b1;
        rdy  = inflight && cyc == g_cyc + L + 2;
        e_d  = rdy && own_d;
        e_if = rdy && !own_d && !aband && !bus.if_flush;
        check("busy", 32'(bus.busy), 32'(inflight));
        check("mem_en", 32'(bus.mem_en), 32'(e_en));
        check("if_ready", 32'(bus.if_ready), 32'(e_if));
        check("d_ready", 32'(bus.d_ready), 32'(e_d));
        check("if_rdata", bus.if_rdata, exp_if_rdata);
        check("d_rdata", bus.d_rdata, exp_d_rdata);
        check("gnt_d", 32'(bus.gnt_d), 32'(exp_gnt_d));
        if (e_en) begin
            check("mem_addr", bus.mem_addr, exp_maddr);
            check("mem_wstrb", 32'(bus.mem_wstrb), 32'(exp_mwstrb));
            if (exp_mwstrb != 4'h0)
                check("mem_wdata", bus.mem_wdata, exp_mwdata);
        end
        if_done = e_if;
        d_done  = e_d;
        if (inflight && cyc == g_cyc + L + 1 && !aband) begin
            if (own_d) exp_d_rdata = pend;
            else       exp_if_rdata = pend;
        end
        if (rdy) inflight = 1'b0;
        if (idle) begin
            eff_if = bus.if_req && !bus.if_flush;
            if (bus.d_req || eff_if) begin
                pick_d = bus.d_req && !(eff_if && streak == MAXS);
                if (pick_d && eff_if) streak = (streak < MAXS) ? streak + 1 : MAXS;
                else                  streak = 0;
                own_d      = pick_d;
                exp_gnt_d  = pick_d;
                inflight   = 1'b1;
                aband      = 1'b0;
                g_cyc      = cyc;
                exp_maddr  = pick_d ? bus.d_addr : bus.if_addr;
                exp_mwstrb = pick_d ? bus.d_wstrb : 4'h0;
                exp_mwdata = pick_d ? bus.d_wdata : '0;
                i  = int'(exp_maddr[9:2]);
                mv = ref_rd(i);
                pend = (exp_mwstrb != 4'h0) ? 32'h0 : mv;
                if (exp_mwstrb != 4'h0) begin
                    ref_mem[i] = merge(mv, exp_mwdata, exp_mwstrb);
                    ref_wr[i]  = 1'b1;
                end
            end
        end
    endtask

    task automatic run_cycle();
        eval();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic agents(input int p_if, input int p_d, input int p_fl);
        bus.if_flush = 1'b0;
        if (if_done) if_pend = 1'b0;
        if ($urandom_range(99) < p_fl) begin
            bus.if_flush = 1'b1;
            if_pend      = 1'b1;
            bus.if_addr  = {22'd0, 8'($urandom_range(255)), 2'b00};
        end else if (!if_pend && $urandom_range(99) < p_if) begin
            if_pend     = 1'b1;
            bus.if_addr = {22'd0, 8'($urandom_range(255)), 2'b00};
        end
        bus.if_req = if_pend;
        if (d_done) d_pend = 1'b0;
        if (!d_pend && $urandom_range(99) < p_d) begin
            d_pend      = 1'b1;
            bus.d_addr  = {22'd0, 8'($urandom_range(255)), 2'b00};
            bus.d_wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            bus.d_wdata = $urandom;
        end
        bus.d_req = d_pend;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        g_cyc  = -100;
        own_d  = 1'b0;
        pend   = '0;
        if_pend = 1'b0;
        d_pend  = 1'b0;
        for (int i = 0; i < 256; i++) ref_wr[i] = 1'b0;
        model_reset();
        rst          = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.d_req    = 1'b0;
        bus.d_addr   = '0;
        bus.d_wstrb  = 4'h0;
        bus.d_wdata  = '0;
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        rst = 1'b1;

        // Lone fetch of address 0.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        if_pend     = 1'b1;
        repeat (8) begin run_cycle(); agents(0, 0, 0); end

        // Fetch and load collide; load wins first.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4;
        if_pend     = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h100;
        bus.d_wstrb = 4'h0;
        bus.d_wdata = '0;
        d_pend      = 1'b1;
        repeat (12) begin run_cycle(); agents(0, 0, 0); end

        // Both requesters saturated: streak limit lets fetch through.
        repeat (60) begin agents(100, 100, 0); run_cycle(); end
        repeat (12) begin agents(0, 0, 0); run_cycle(); end

        // Fetch of 0x0C abandoned during WAIT; 0x10 follows.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'hC;
        if_pend     = 1'b1;
        run_cycle();
        run_cycle();
        bus.if_flush = 1'b1;
        bus.if_addr  = 32'h10;
        run_cycle();
        repeat (8) begin agents(0, 0, 0); run_cycle(); end

        // Full-word store, then read it back.
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wstrb = 4'hF;
        bus.d_wdata = 32'h7;
        d_pend      = 1'b1;
        repeat (7) begin run_cycle(); agents(0, 0, 0); end
        bus.d_req   = 1'b1;
        bus.d_wstrb = 4'h0;
        d_pend      = 1'b1;
        repeat (7) begin run_cycle(); agents(0, 0, 0); end

        // Mixed random traffic with flushes.
        repeat (600) begin agents(60, 50, 6); run_cycle(); end
        repeat (12) begin agents(0, 0, 0); run_cycle(); end

        // Asynchronous reset while a load sits in WAIT.
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h104;
        bus.d_wstrb = 4'h0;
        d_pend      = 1'b1;
        run_cycle();
        run_cycle();
        check("pre_rst_busy", 32'(bus.busy), 32'(1));
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_mem_en", 32'(bus.mem_en), 32'(0));
        check("rst_d_ready", 32'(bus.d_ready), 32'(0));
        check("rst_if_ready", 32'(bus.if_ready), 32'(0));
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        model_reset();
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        d_pend     = 1'b0;
        if_pend    = 1'b0;
        run_cycle();
        rst = 1'b1;
        repeat (8) begin agents(0, 0, 0); run_cycle(); end
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        if_pend     = 1'b1;
        repeat (6) begin run_cycle(); agents(0, 0, 0); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
